fb_draw_writer: RTL and testbench

Framebuffer write engine: the producer side of the bram_sdp framebuffer that the display path reads and scales. It accepts draw commands (plot, filled rectangle, clear) over a valid/ready handshake. It clips each command to the framebuffer and writes one pixel per cycle into the write port (we/addr_write/data_in), in the system clock domain.

---
 rtl/fb_draw_pkg.sv | 22 ++
 rtl/fb_draw_writer_clip.sv | 32 +++
 rtl/fb_draw_writer.sv | 210 +++++++++++++++++++++
 tb/tb_fb_draw_writer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_draw_pkg.sv
// Shared types and constants for the framebuffer draw writers.
// Optional feature macro used by fb_draw_writer: FB_WR_VSYNC_EN.
package fb_draw_pkg;

  localparam int CORDW_DEF = 16;
  localparam int CIDXW_DEF = 4;

  typedef enum logic [1:0] {
    OP_PLOT  = 2'd0,
    OP_RECT  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } draw_op_t;

  // Writer FSM encoding, kept as plain constants for legacy tools.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/fb_draw_writer_clip.sv
// fb_clip: combinational clip of one inclusive rectangle to the framebuffer.
// Produces clipped corners and an empty flag (inverted or fully off-screen).
module fb_clip
  import fb_draw_pkg::*;
#(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int CORDW     = CORDW_DEF
) (
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] cx0,
  output logic signed [CORDW-1:0] cy0,
  output logic signed [CORDW-1:0] cx1,
  output logic signed [CORDW-1:0] cy1,
  output logic                    empty
);

  localparam logic signed [CORDW-1:0] XMAX = CORDW'(FB_WIDTH - 1);
  localparam logic signed [CORDW-1:0] YMAX = CORDW'(FB_HEIGHT - 1);
  localparam logic signed [CORDW-1:0] ZERO = '0;

  // All comparisons are signed so negative corners clamp to zero.
  assign cx0   = (x0 < ZERO) ? ZERO : x0;
  assign cy0   = (y0 < ZERO) ? ZERO : y0;
  assign cx1   = (x1 > XMAX) ? XMAX : x1;
  assign cy1   = (y1 > YMAX) ? YMAX : y1;
  assign empty = (cx0 > cx1) || (cy0 > cy1);

endmodule

// File: rtl/fb_draw_writer.sv
// fb_draw_writer: accepts plot/rect/clear commands, clips them and writes
// one pixel per cycle into the framebuffer write port (clk_sys domain).
// Optional: define FB_WR_VSYNC_EN to hold each fill until frame_sys.
module fb_draw_writer
  import fb_draw_pkg::*;
#(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int CORDW     = CORDW_DEF,
  parameter int CIDXW     = CIDXW_DEF,
  parameter int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys,
  input  logic                    frame_sys,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic signed [CORDW-1:0] cmd_x0,
  input  logic signed [CORDW-1:0] cmd_y0,
  input  logic signed [CORDW-1:0] cmd_x1,
  input  logic signed [CORDW-1:0] cmd_y1,
  input  logic [CIDXW-1:0]        cmd_colr,
  output logic                    fb_we,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [CIDXW-1:0]        fb_colr,
  output logic                    busy,
  output logic                    done
);

  localparam logic [FB_ADDRW-1:0] LINE_STEP = FB_ADDRW'(FB_WIDTH);

  logic [2:0]              state;

  // Command registered at accept, already normalised to a rectangle.
  logic signed [CORDW-1:0] r_x0, r_y0, r_x1, r_y1;
  logic [CIDXW-1:0]        r_colr;

  // Normalised command presented at the input (used only at accept).
  logic signed [CORDW-1:0] n_x0, n_y0, n_x1, n_y1;

  // Clipped bounds of the registered command.
  logic signed [CORDW-1:0] c_cx0, c_cy0, c_cx1, c_cy1;
  logic                    c_empty;

  // Fill walk state: clipped bounds and current pixel.
  logic signed [CORDW-1:0] cx0_q, cx1_q, cy1_q;
  logic signed [CORDW-1:0] x_q, y_q;
  logic [FB_ADDRW-1:0]     row_base;

  logic [FB_ADDRW-1:0]     setup_base;
  logic [FB_ADDRW-1:0]     cx0_addr;

`ifndef FB_WR_VSYNC_EN
  logic unused_frame;
  assign unused_frame = frame_sys;
`endif

  assign cmd_ready = (state == ST_IDLE) && !rst_sys;
  assign busy      = (state != ST_IDLE);

  // Map every opcode onto an inclusive rectangle before it is registered.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    n_x0 = cmd_x0;
    n_y0 = cmd_y0;
    n_x1 = cmd_x1;
    n_y1 = cmd_y1;
    case (draw_op_t'(cmd_op))
      OP_PLOT: begin
        n_x1 = cmd_x0;
        n_y1 = cmd_y0;
      end
      OP_RECT: ;
      OP_CLEAR: begin
        n_x0 = '0;
        n_y0 = '0;
        n_x1 = CORDW'(FB_WIDTH - 1);
        n_y1 = CORDW'(FB_HEIGHT - 1);
      end
      default: begin
        // Reserved: x0 > x1 makes the rectangle empty.
        n_x0 = CORDW'(1);
        n_y0 = '0;
        n_x1 = '0;
        n_y1 = '0;
      end
    endcase
  end

  fb_clip #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .CORDW     (CORDW)
  ) u_clip (
    .x0    (r_x0),
    .y0    (r_y0),
    .x1    (r_x1),
    .y1    (r_y1),
    .cx0   (c_cx0),
    .cy0   (c_cy0),
    .cx1   (c_cx1),
    .cy1   (c_cy1),
    .empty (c_empty)
  );

  // Clipped corners are non-negative, so reinterpreting them as unsigned
  // addresses is safe; this is the only multiply in the engine.
  assign setup_base = FB_ADDRW'($unsigned(c_cy0)) * LINE_STEP;
  assign cx0_addr   = FB_ADDRW'($unsigned(cx0_q));

  // Command FSM and fill walker; all outputs are registered here.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state    <= ST_IDLE;
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_colr   <= '0;
      cx0_q    <= '0;
      cx1_q    <= '0;
      cy1_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      row_base <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_colr  <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_x0   <= n_x0;
            r_y0   <= n_y0;
            r_x1   <= n_x1;
            r_y1   <= n_y1;
            r_colr <= cmd_colr;
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          cx0_q    <= c_cx0;
          cx1_q    <= c_cx1;
          cy1_q    <= c_cy1;
          x_q      <= c_cx0;
          y_q      <= c_cy0;
          row_base <= setup_base;
          fb_addr  <= setup_base + FB_ADDRW'($unsigned(c_cx0));
          fb_colr  <= r_colr;
          if (c_empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
`ifdef FB_WR_VSYNC_EN
            // A frame pulse during SETUP is deliberately not sampled.
            state <= ST_WAIT;
`else
            state <= ST_FILL;
            fb_we <= 1'b1;
`endif
          end
        end

        ST_WAIT: begin
`ifdef FB_WR_VSYNC_EN
          if (frame_sys) begin
            state <= ST_FILL;
            fb_we <= 1'b1;
          end
`else
          state <= ST_IDLE;
`endif
        end

        ST_FILL: begin
          if (x_q == cx1_q) begin
            if (y_q == cy1_q) begin
              state <= ST_DONE;
              fb_we <= 1'b0;
              done  <= 1'b1;
            end else begin
              x_q      <= cx0_q;
              y_q      <= y_q + CORDW'(1);
              row_base <= row_base + LINE_STEP;
              fb_addr  <= row_base + LINE_STEP + cx0_addr;
            end
          end else begin
            x_q     <= x_q + CORDW'(1);
            fb_addr <= fb_addr + FB_ADDRW'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          fb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_draw_writer.sv
// Self-checking bench for fb_draw_writer against a pixel-list model.
// Honours FB_WR_VSYNC_EN when the design is built with it.
module tb_fb_draw_writer;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int CORDW = 16;
  localparam int CIDXW = 4;
  localparam int AW    = 15;
`ifdef FB_WR_VSYNC_EN
  localparam int LAT = 5;  // frame pulse at accept+4, first write at accept+5
`else
  localparam int LAT = 2;
`endif

  logic                    clk_sys = 1'b0;
  logic                    rst_sys = 1'b1;
  logic                    frame_sys = 1'b0;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [1:0]              cmd_op = '0;
  logic signed [CORDW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [CIDXW-1:0]        cmd_colr = '0;
  logic                    fb_we;
  logic [AW-1:0]           fb_addr;
  logic [CIDXW-1:0]        fb_colr;
  logic                    busy;
  logic                    done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_k = 0;
  int ready_k = 0;

  int mon_addr[$];
  int mon_colr[$];
  int mon_cyc[$];
  int done_cyc[$];
  int exp_addr[$];

  fb_draw_writer #(
    .FB_WIDTH  (W),
    .FB_HEIGHT (H),
    .CORDW     (CORDW),
    .CIDXW     (CIDXW),
    .FB_ADDRW  (AW)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys   (rst_sys),
    .frame_sys (frame_sys),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_colr  (cmd_colr),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_colr   (fb_colr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Record every write and done pulse, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (fb_we === 1'b1) begin
      mon_addr.push_back(int'(fb_addr));
      mon_colr.push_back(int'(fb_colr));
      mon_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  // Reference: list of pixel addresses a command should touch, in order.
  function automatic void model(int op, int x0, int y0, int x1, int y1);
    int ax0, ay0, ax1, ay1;
    exp_addr.delete();
    case (op)
      0: begin ax0 = x0; ay0 = y0; ax1 = x0; ay1 = y0; end
      1: begin ax0 = x0; ay0 = y0; ax1 = x1; ay1 = y1; end
      2: begin ax0 = 0; ay0 = 0; ax1 = W - 1; ay1 = H - 1; end
      default: return;
    endcase
    for (int y = (ay0 < 0 ? 0 : ay0); y <= (ay1 > H - 1 ? H - 1 : ay1); y++)
      for (int x = (ax0 < 0 ? 0 : ax0); x <= (ax1 > W - 1 ? W - 1 : ax1); x++)
        exp_addr.push_back(y * W + x);
  endfunction

  // -1 when observed writes equal the model list, else first bad index.
  function automatic int first_diff();
    if (mon_addr.size() != exp_addr.size()) return -2;
    foreach (exp_addr[i]) if (mon_addr[i] != exp_addr[i]) return i;
    return -1;
  endfunction

  function automatic int colr_bad(int c);
    int n = 0;
    foreach (mon_colr[i]) if (mon_colr[i] != c) n++;
    return n;
  endfunction

  function automatic int exp_done(int n);
    return (n == 0) ? acc_k + 1 : acc_k + LAT - 1 + n;
  endfunction

  function automatic bit timing_ok(int n);
    if (n == 0) return mon_cyc.size() == 0;
    if (mon_cyc.size() != n) return 1'b0;
    return (mon_cyc[0] == acc_k + LAT - 1) && (mon_cyc[n-1] == acc_k + LAT - 2 + n);
  endfunction

  function automatic void clear_mon();
    mon_addr.delete(); mon_colr.delete(); mon_cyc.delete(); done_cyc.delete();
  endfunction

  task automatic send(int op, int x0, int y0, int x1, int y1, int colr);
    clear_mon();
    model(op, x0, y0, x1, y1);
    @(negedge clk_sys);
    cmd_op = 2'(op); cmd_x0 = CORDW'(x0); cmd_y0 = CORDW'(y0);
    cmd_x1 = CORDW'(x1); cmd_y1 = CORDW'(y1); cmd_colr = CIDXW'(colr);
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge clk_sys);
    if (cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout cmd_ready=%b required=1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
    acc_k = cyc;
    cmd_valid = 1'b0;
    // Scramble inputs: the engine must use only the accepted values.
    cmd_x0 = CORDW'($urandom); cmd_y0 = CORDW'($urandom);
    cmd_x1 = CORDW'($urandom); cmd_y1 = CORDW'($urandom);
    cmd_colr = CIDXW'($urandom); cmd_op = 2'($urandom);
    frame_sys = 1'b1;  // coincides with SETUP, must not release a vsync wait
  endtask

  task automatic wait_idle(int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      frame_sys = (cyc == acc_k + 3);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    frame_sys = 1'b0;
    ready_k = cyc;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL idle_timeout cmd_ready=%b required=1 within %0d cycles", cmd_ready, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({fb_we, fb_addr, fb_colr, done, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs we=%b addr=%0d colr=%0d done=%b busy=%b required all 0",
               fb_we, fb_addr, fb_colr, done, busy);
    end
    rst_sys = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_plot();
    send(0, 3, 2, 50, 60, 5);
    wait_idle(100);
    checks++;
    if (mon_addr.size() != 1 || mon_addr[0] != 323 || mon_colr[0] != 5) begin
      failures++;
      $display("FAIL plot_write n=%0d addr=%0d colr=%0d required n=1 addr=323 colr=5",
               mon_addr.size(), mon_addr.size() ? mon_addr[0] : -1,
               mon_colr.size() ? mon_colr[0] : -1);
    end
    checks++;
    if (!timing_ok(1)) begin
      failures++;
      $display("FAIL plot_we_cycle got=%0d required=%0d",
               mon_cyc.size() ? mon_cyc[0] - acc_k + 1 : -1, LAT);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != acc_k + LAT || ready_k != acc_k + LAT + 1) begin
      failures++;
      $display("FAIL plot_done ndone=%0d done_rel=%0d ready_rel=%0d required 1/%0d/%0d",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] - acc_k + 1 : -1,
               ready_k - acc_k + 1, LAT + 1, LAT + 2);
    end
  endtask

  task automatic test_rect_clip();
    send(1, -2, -1, 1, 0, 9);
    wait_idle(100);
    checks++;
    if (mon_addr.size() != 2 || mon_addr[0] != 0 || mon_addr[1] != 1 || colr_bad(9) != 0) begin
      failures++;
      $display("FAIL rect_clip_writes n=%0d first=%0d required n=2 addr 0,1 colr 9",
               mon_addr.size(), mon_addr.size() ? mon_addr[0] : -1);
    end
    checks++;
    if (!timing_ok(2) || done_cyc.size() != 1 || done_cyc[0] != exp_done(2)) begin
      failures++;
      $display("FAIL rect_clip_timing ndone=%0d done=%0d required 1/%0d",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, exp_done(2));
    end
  endtask

  task automatic test_empty();
    int c[2][4] = '{'{10, 5, 4, 7}, '{200, 0, 210, 3}};
    for (int i = 0; i < 2; i++) begin
      send(1, c[i][0], c[i][1], c[i][2], c[i][3], 6);
      wait_idle(100);
      checks++;
      if (mon_addr.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != acc_k + 1 ||
          ready_k != acc_k + 2) begin
        failures++;
        $display("FAIL empty_rect%0d writes=%0d ndone=%0d done_rel=%0d required 0/1/2",
                 i, mon_addr.size(), done_cyc.size(),
                 done_cyc.size() ? done_cyc[0] - acc_k + 1 : -1);
      end
    end
    // Reserved opcode is a no-op that still completes.
    send(3, 0, 0, 20, 20, 2);
    wait_idle(100);
    checks++;
    if (mon_addr.size() != 0 || done_cyc.size() != 1) begin
      failures++;
      $display("FAIL reserved_op writes=%0d ndone=%0d required 0/1", mon_addr.size(), done_cyc.size());
    end
  endtask

  task automatic test_clear();
    send(2, 33, 44, -5, -5, 0);
    wait_idle(W * H + 100);
    checks++;
    if (first_diff() != -1 || colr_bad(0) != 0) begin
      failures++;
      $display("FAIL clear_addrs n=%0d diff_at=%0d required n=%0d in order",
               mon_addr.size(), first_diff(), W * H);
    end
    checks++;
    if (!timing_ok(W * H) || done_cyc.size() != 1 || done_cyc[0] != exp_done(W * H)) begin
      failures++;
      $display("FAIL clear_timing n=%0d ndone=%0d required contiguous %0d, done once",
               mon_cyc.size(), done_cyc.size(), W * H);
    end
  endtask

  task automatic test_back_to_back();
    int k1, ready1, acc_x;
    bit got = 1'b0;
    clear_mon();
    @(negedge clk_sys);
    cmd_op = 2'd1; cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 9; cmd_y1 = 1; cmd_colr = 4'd3;
    cmd_valid = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    k1 = cyc;
    frame_sys = 1'b1;
    cmd_op = 2'd0; cmd_y0 = 5; cmd_colr = 4'd7;
    acc_x = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_sys);
      frame_sys = (cyc == k1 + 3);
      cmd_x0 = CORDW'($urandom_range(0, 150));
      if (cmd_ready === 1'b1) begin got = 1'b1; acc_x = int'(cmd_x0); end
    end
    ready1 = cyc;
    @(posedge clk_sys);
    @(negedge clk_sys);
    acc_k = cyc;
    cmd_valid = 1'b0;
    frame_sys = 1'b1;
    wait_idle(100);
    exp_addr.delete();
    for (int y = 0; y < 2; y++) for (int x = 0; x < 10; x++) exp_addr.push_back(y * W + x);
    exp_addr.push_back(5 * W + acc_x);
    checks++;
    if (!got || ready1 != k1 + LAT + 20) begin
      failures++;
      $display("FAIL b2b_accept got=%0d ready_rel=%0d required ready_rel=%0d",
               got, ready1 - k1 + 1, LAT + 21);
    end
    checks++;
    if (first_diff() != -1 || mon_colr.size() != 21 || mon_colr[19] != 3 || mon_colr[20] != 7) begin
      failures++;
      $display("FAIL b2b_writes n=%0d diff_at=%0d required 21 writes, rect colr 3 then plot colr 7",
               mon_addr.size(), first_diff());
    end
    checks++;
    if (done_cyc.size() != 2 || done_cyc[1] != acc_k + LAT) begin
      failures++;
      $display("FAIL b2b_done ndone=%0d required 2", done_cyc.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int op, x0, y0, x1, y1, colr, n;
      op = int'($urandom_range(0, 3));
      if (op == 2) op = 1;
      x0 = int'($urandom_range(0, 200)) - 20;
      y0 = int'($urandom_range(0, 140)) - 10;
      x1 = x0 + int'($urandom_range(0, 34)) - 4;
      y1 = y0 + int'($urandom_range(0, 14)) - 3;
      colr = int'($urandom_range(0, 15));
      send(op, x0, y0, x1, y1, colr);
      n = exp_addr.size();
      wait_idle(1000);
      checks++;
      if (first_diff() != -1 || colr_bad(colr) != 0) begin
        failures++;
        $display("FAIL rand%0d_writes op=%0d (%0d,%0d)-(%0d,%0d) n=%0d required=%0d diff_at=%0d",
                 it, op, x0, y0, x1, y1, mon_addr.size(), n, first_diff());
      end
      checks++;
      if (!timing_ok(n) || done_cyc.size() != 1 || done_cyc[0] != exp_done(n) ||
          ready_k != exp_done(n) + 1) begin
        failures++;
        $display("FAIL rand%0d_timing ndone=%0d done=%0d ready=%0d required done=%0d ready=%0d",
                 it, done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, ready_k,
                 exp_done(n), exp_done(n) + 1);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    bit hit = 1'b0;
    send(2, 0, 0, 0, 0, 12);
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk_sys);
      frame_sys = (cyc == acc_k + 3);
      if (fb_we === 1'b1 && fb_addr == AW'(500)) hit = 1'b1;
    end
    frame_sys = 1'b0;
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rst_mid_reach addr=%0d required 500", fb_addr);
    end
    rst_sys = 1'b1;
    #1;
    checks++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || fb_addr !== '0) begin
      failures++;
      $display("FAIL rst_mid_async we=%b busy=%b addr=%0d required 0/0/0", fb_we, busy, fb_addr);
    end
    repeat (2) @(negedge clk_sys);
    clear_mon();
    rst_sys = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_sys);
      frame_sys = (i % 7 == 3);
    end
    frame_sys = 1'b0;
    checks++;
    if (mon_addr.size() != 0 || done_cyc.size() != 0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_after writes=%0d ndone=%0d cmd_ready=%b required 0/0/1",
               mon_addr.size(), done_cyc.size(), cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_plot();
    test_rect_clip();
    test_empty();
    test_clear();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
